// File: rtl/display_value_controller.sv
// Binary-to-decimal display sequencer: double-dabble conversion followed by a
// single formatting cycle that publishes blank/sign/digit codes per position.
module display_value_controller #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 6
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Load,
    input  logic                  IsSigned,
    input  logic [WIDTH-1:0]      Value,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   DigitCodes
);

    localparam int BW = 4 * (DIGITS - 1);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(DIGITS) + 1;

    localparam logic [3:0] CODE_MINUS = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FORMAT
    } state_t;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] codes_q, codes_d, codes_fmt;
    logic                done_q, done_d;
    logic [IW-1:0]       msd;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            codes_q <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            codes_q <= codes_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        codes_d = codes_q;
        done_d  = 1'b0;

        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS - 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if (Load) begin
                    sign_d  = IsSigned & Value[WIDTH-1];
                    mag_d   = sign_d ? (~Value + 1'b1) : Value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, mag_d} = {bcd_adj[BW-2:0], mag_q, 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = FORMAT;
            end
            FORMAT: begin
                codes_d = codes_fmt;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit 0 is always shown; the sign sits just left of the leading digit.
    always_comb begin
        msd = '0;
        for (int unsigned i = 1; i < DIGITS - 1; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0)
                msd = IW'(i);
        end
        codes_fmt = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((i < DIGITS - 1) && (IW'(i) <= msd))
                codes_fmt[4*i +: 4] = bcd_q[4*i +: 4];
            else if (sign_q && (IW'(i) == msd + 1'b1))
                codes_fmt[4*i +: 4] = CODE_MINUS;
            else
                codes_fmt[4*i +: 4] = CODE_BLANK;
        end
    end

    always_comb begin
        Busy       = (state_q != IDLE);
        Done       = done_q;
        DigitCodes = codes_q;
    end

endmodule

// File: tb/tb_display_value_controller.sv
// Self-checking bench for display_value_controller (WIDTH=16, DIGITS=6) using
// an arithmetic decimal-formatting reference model.
module tb_display_value_controller;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 6;

    logic                  Clock;
    logic                  Resetn;
    logic                  Load;
    logic                  IsSigned;
    logic [WIDTH-1:0]      Value;
    logic                  Busy;
    logic                  Done;
    logic [4*DIGITS-1:0]   DigitCodes;

    int n_cmp = 0;
    int n_err = 0;

    display_value_controller #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Load       (Load),
        .IsSigned   (IsSigned),
        .Value      (Value),
        .Busy       (Busy),
        .Done       (Done),
        .DigitCodes (DigitCodes)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Decimal rendering of the value, right-aligned, with leading minus sign.
    function automatic logic [4*DIGITS-1:0] model(input logic [WIDTH-1:0] v, input logic s);
        logic [4*DIGITS-1:0] r;
        int unsigned m;
        int n;
        bit neg;
        neg = s && v[WIDTH-1];
        m = neg ? (32'd1 << WIDTH) - int'(v) : int'(v);
        r = '1;
        n = 0;
        do begin
            r[4*n +: 4] = 4'(m % 10);
            m = m / 10;
            n++;
        end while (m != 0);
        if (neg) r[4*n +: 4] = 4'd11;
        return r;
    endfunction

    // Drives one load (caller is between clock edges) and observes edges 1..18.
    task automatic run_conv(input logic [WIDTH-1:0] v, input logic s, input bit poke,
                            output int busy_cnt, output int done_cnt,
                            output logic [4*DIGITS-1:0] codes, output bit held);
        logic [4*DIGITS-1:0] prev;
        prev = DigitCodes;
        Load = 1'b1; Value = v; IsSigned = s;
        @(posedge Clock); #1;
        Load = 1'b0; Value = 16'($urandom); IsSigned = 1'($urandom);
        busy_cnt = 0; done_cnt = 0; held = 1'b1;
        for (int e = 1; e <= WIDTH + 2; e++) begin
            if (e > 1) begin @(posedge Clock); #1; end
            if (Busy) busy_cnt++;
            if (Done) done_cnt++;
            if (e < WIDTH + 2 && DigitCodes !== prev) held = 1'b0;
            if (poke && e == 5) begin Load = 1'b1; Value = 16'd7; IsSigned = 1'b0; end
            else if (poke && e == 6) Load = 1'b0;
        end
        codes = DigitCodes;
    endtask

    task automatic test_reset;
        Load = 1'b0; IsSigned = 1'b0; Value = '0; Resetn = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock); Resetn = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        n_cmp++; if (DigitCodes !== 24'hFFFFFF) begin n_err++; $display("FAIL reset_codes: got %h want %h", DigitCodes, 24'hFFFFFF); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", Done); end
        @(negedge Clock);
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0]    tv [6] = '{16'd1234, 16'hFFF6, 16'h8000, 16'h8000, 16'd0, 16'hFFFF};
        logic                ts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [4*DIGITS-1:0] te [6] = '{24'hFF1234, 24'hFFFB10, 24'hB32768, 24'hF32768, 24'hFFFFF0, 24'hF65535};
        int bc, dc; logic [4*DIGITS-1:0] c; bit h;
        for (int k = 0; k < 6; k++) begin
            run_conv(tv[k], ts[k], 1'b0, bc, dc, c, h);
            n_cmp++; if (c !== te[k]) begin n_err++; $display("FAIL directed_codes[%0d]: got %h want %h", k, c, te[k]); end
            n_cmp++; if (bc !== WIDTH + 1) begin n_err++; $display("FAIL directed_busy[%0d]: got %0d cycles want %0d", k, bc, WIDTH + 1); end
            n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL directed_done[%0d]: got %0d pulses want 1", k, dc); end
            n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL directed_hold[%0d]: codes changed mid-conversion", k); end
            @(negedge Clock);
        end
    endtask

    task automatic test_random;
        int bc, dc; logic [4*DIGITS-1:0] c, exp; bit h;
        logic [WIDTH-1:0] v; logic s;
        for (int k = 0; k < 25; k++) begin
            v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom);
            s = 1'($urandom);
            exp = model(v, s);
            run_conv(v, s, 1'b0, bc, dc, c, h);
            n_cmp++; if (c !== exp) begin n_err++; $display("FAIL random_codes v=%h s=%b: got %h want %h", v, s, c, exp); end
            n_cmp++; if (dc !== 1 || h !== 1'b1) begin n_err++; $display("FAIL random_seq v=%h: done=%0d held=%b want 1/1", v, dc, h); end
            @(negedge Clock);
        end
    endtask

    task automatic test_ignore_load;
        int bc, dc; logic [4*DIGITS-1:0] c; bit h;
        run_conv(16'd1234, 1'b1, 1'b1, bc, dc, c, h);
        n_cmp++; if (c !== 24'hFF1234) begin n_err++; $display("FAIL ignore_load_codes: got %h want %h", c, 24'hFF1234); end
        n_cmp++; if (bc !== WIDTH + 1) begin n_err++; $display("FAIL ignore_load_busy: got %0d want %0d", bc, WIDTH + 1); end
        @(posedge Clock); #1;
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL ignore_load_queued: busy=%b want 0", Busy); end
        @(negedge Clock);
    endtask

    task automatic test_back_to_back;
        int bc, dc; logic [4*DIGITS-1:0] c; bit h;
        run_conv(16'd1234, 1'b1, 1'b0, bc, dc, c, h);
        n_cmp++; if (c !== 24'hFF1234) begin n_err++; $display("FAIL b2b_first: got %h want %h", c, 24'hFF1234); end
        // Still inside the Done cycle: this load must be accepted.
        run_conv(16'd5, 1'b0, 1'b0, bc, dc, c, h);
        n_cmp++; if (c !== 24'hFFFFF5) begin n_err++; $display("FAIL b2b_second: got %h want %h", c, 24'hFFFFF5); end
        n_cmp++; if (bc !== WIDTH + 1 || dc !== 1) begin n_err++; $display("FAIL b2b_seq: busy=%0d done=%0d want %0d/1", bc, dc, WIDTH + 1); end
        @(posedge Clock); #1;
        n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b want 0", Done); end
        @(negedge Clock);
    endtask

    task automatic test_reset_mid;
        int bc, dc, seen; logic [4*DIGITS-1:0] c; bit h;
        Load = 1'b1; Value = 16'd4321; IsSigned = 1'b0;
        @(posedge Clock); #1; Load = 1'b0;
        repeat (5) @(posedge Clock);
        #2; Resetn = 1'b0; #1;
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_mid_busy: got %b want 0", Busy); end
        n_cmp++; if (DigitCodes !== 24'hFFFFFF) begin n_err++; $display("FAIL reset_mid_codes: got %h want %h", DigitCodes, 24'hFFFFFF); end
        @(negedge Clock); Resetn = 1'b1;
        seen = 0;
        for (int e = 0; e < WIDTH + 4; e++) begin
            @(posedge Clock); #1;
            if (Done) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL reset_mid_nodone: got %0d pulses want 0", seen); end
        @(negedge Clock);
        run_conv(16'hFF85, 1'b1, 1'b0, bc, dc, c, h);
        n_cmp++; if (c !== model(16'hFF85, 1'b1)) begin n_err++; $display("FAIL reset_mid_reload: got %h want %h", c, model(16'hFF85, 1'b1)); end
        @(negedge Clock);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_load;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
